// File: rtl/mouse_counter_pkg.sv
// Shared constants, snapshot FSM state type and packing helpers for the
// mouse button press counter array.
package mouse_counter_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } snap_state_t;

   // All-ones value for a counter of the given width (width <= 16).
   function automatic logic [15:0] max_count(input int width);
      return 16'((32'd1 << width) - 32'd1);
   endfunction

   // Low bit index of a channel slice in a packed multi-channel bus.
   function automatic int chan_lo(input int chan, input int width);
      return chan * width;
   endfunction

endpackage

// File: rtl/button_debounce_counter.sv
// One button channel: debounce filter, rising-edge detector, press counter
// with wrap/saturate behaviour and sticky overflow flag.
module button_debounce_counter
   import mouse_counter_pkg::*;
#(
   parameter int CNT_WIDTH       = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SATURATE        = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn,
   input  logic                 clear,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 ovf
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(max_count(CNT_WIDTH));
   localparam logic [7:0]           STAB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic       filt_p0;
   logic       filt_p1;
   logic [7:0] stab;
   logic       press_evt;

   // Stage p0: filtered level moves only after the raw level has differed
   // for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_p0 <= 1'b0;
         stab    <= 8'd0;
      end else if (btn == filt_p0) begin
         stab <= 8'd0;
      end else if (stab == STAB_LAST) begin
         filt_p0 <= btn;
         stab    <= 8'd0;
      end else begin
         stab <= stab + 8'd1;
      end
   end

   // Stage p1: delayed filtered level for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_p1 <= 1'b0;
      end else begin
         filt_p1 <= filt_p0;
      end
   end

   assign press_evt = filt_p0 & ~filt_p1;

   // Counter stage: clear beats a same-cycle press.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (press_evt) begin
         if (count == CNT_MAX) begin
            ovf <= 1'b1;
            if (SATURATE != MODE_SAT) begin
               count <= '0;
            end
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mouse_button_counter_array.sv
// Array of debounced press counters with per-channel clear, sticky overflow
// flags and an atomic snapshot readout behind a valid/ready handshake.
module mouse_button_counter_array
   import mouse_counter_pkg::*;
#(
   parameter int NUM_BUTTONS     = 3,
   parameter int CNT_WIDTH       = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SATURATE        = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_BUTTONS-1:0]           buttons,
   input  logic [NUM_BUTTONS-1:0]           clear_mask,
   input  logic                             clear_all,
   input  logic                             snap_req,
   output logic                             snap_valid,
   input  logic                             snap_ready,
   output logic [NUM_BUTTONS*CNT_WIDTH-1:0] snap_data,
   output logic [NUM_BUTTONS*CNT_WIDTH-1:0] counters,
   output logic [NUM_BUTTONS-1:0]           overflow
);

   logic [CNT_WIDTH-1:0] count_arr [NUM_BUTTONS];
   logic                 ovf_arr   [NUM_BUTTONS];

   snap_state_t state;
   snap_state_t state_next;
   logic        capture;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      button_debounce_counter #(
         .CNT_WIDTH       (CNT_WIDTH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SATURATE        (SATURATE)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .btn   (buttons[i]),
         .clear (clear_all | clear_mask[i]),
         .count (count_arr[i]),
         .ovf   (ovf_arr[i])
      );
   end

   always_comb begin
      counters = '0;
      overflow = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         counters[chan_lo(i, CNT_WIDTH) +: CNT_WIDTH] = count_arr[i];
         overflow[i] = ovf_arr[i];
      end
   end

   // Handshake state: HOLD means snap_data is valid and frozen.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (snap_req) begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (snap_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign snap_valid = (state == HOLD);

   // Captures the registered counters, i.e. values before this cycle's updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_data <= '0;
      end else if (capture) begin
         snap_data <= counters;
      end
   end

endmodule

// File: tb/tb_mouse_button_counter_array.sv
// Directed bench for the press counter array: a default-configured instance
// plus two 2-bit instances (wrap and saturate) checked against a queue of
// expected values computed by a small behavioural model.
module tb_mouse_button_counter_array;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } sb_t;

   sb_t sb_q[$];
   int  errors  = 0;
   int  n_checks = 0;
   int  m_cnt[3];
   int  m_w, m_s;
   logic m_ovf_w, m_ovf_s;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  buttons, clear_mask;
   logic        clear_all, snap_req, snap_ready;
   logic        snap_valid;
   logic [23:0] snap_data, counters;
   logic [2:0]  overflow;

   logic [2:0]  b2, cm2;
   logic        ca2, sr2, rdy2;
   logic        sv_w, sv_s;
   logic [5:0]  sd_w, sd_s, cnt_w, cnt_s;
   logic [2:0]  ovf_w, ovf_s;

   mouse_button_counter_array dut (
      .clk(clk), .rst(rst), .buttons(buttons), .clear_mask(clear_mask),
      .clear_all(clear_all), .snap_req(snap_req), .snap_valid(snap_valid),
      .snap_ready(snap_ready), .snap_data(snap_data), .counters(counters),
      .overflow(overflow)
   );

   mouse_button_counter_array #(.CNT_WIDTH(2), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .buttons(b2), .clear_mask(cm2),
      .clear_all(ca2), .snap_req(sr2), .snap_valid(sv_w),
      .snap_ready(rdy2), .snap_data(sd_w), .counters(cnt_w),
      .overflow(ovf_w)
   );

   mouse_button_counter_array #(.CNT_WIDTH(2), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .buttons(b2), .clear_mask(cm2),
      .clear_all(ca2), .snap_req(sr2), .snap_valid(sv_s),
      .snap_ready(rdy2), .snap_data(sd_s), .counters(cnt_s),
      .overflow(ovf_s)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_val(input string tag, input logic [31:0] val);
      sb_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      sb_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: got %0h with nothing expected", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   function automatic logic [31:0] pk();
      logic [7:0] c0, c1, c2;
      c0 = 8'(m_cnt[0]);
      c1 = 8'(m_cnt[1]);
      c2 = 8'(m_cnt[2]);
      return {8'h00, c2, c1, c0};
   endfunction

   task automatic press(input logic [2:0] m);
      buttons = m;
      tick(7);
      buttons = 3'b000;
      tick(7);
      for (int i = 0; i < 3; i++)
         if (m[i]) m_cnt[i] = (m_cnt[i] + 1) % 256;
   endtask

   task automatic press2();
      b2 = 3'b001;
      tick(6);
      b2 = 3'b000;
      tick(6);
      if (m_w == 3) begin m_w = 0; m_ovf_w = 1'b1; end
      else m_w = m_w + 1;
      if (m_s == 3) m_ovf_s = 1'b1;
      else m_s = m_s + 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; buttons = 0; clear_mask = 0; clear_all = 0;
      snap_req = 0; snap_ready = 0;
      b2 = 0; cm2 = 0; ca2 = 0; sr2 = 0; rdy2 = 0;
      m_cnt = '{0, 0, 0}; m_w = 0; m_s = 0; m_ovf_w = 0; m_ovf_s = 0;
      tick(3);
      expect_val("rst_counters", 0);   chk(32'(counters));
      expect_val("rst_overflow", 0);   chk(32'(overflow));
      expect_val("rst_snap_valid", 0); chk(32'(snap_valid));
      expect_val("rst_snap_data", 0);  chk(32'(snap_data));
      rst = 1'b0;
      tick(1);

      // single press: count appears exactly 5 cycles after first high sample
      buttons = 3'b001;
      expect_val("t1_before_latency", 0);
      expect_val("t1_at_latency", 1);
      tick(4); chk(32'(counters[7:0]));
      tick(1); chk(32'(counters[7:0]));
      tick(5);
      buttons = 3'b000;
      tick(7);
      m_cnt[0] = 1;
      expect_val("t1_all_counters", pk()); chk(32'(counters));
      expect_val("t1_overflow", 0);        chk(32'(overflow));

      // bounce on channel 1, then a 3-cycle glitch on channel 2
      begin
         logic seq [9];
         seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
         for (int i = 0; i < 9; i++) begin
            buttons[1] = seq[i];
            tick(1);
         end
      end
      buttons[1] = 1'b0;
      tick(7);
      buttons[2] = 1'b1;
      tick(3);
      buttons[2] = 1'b0;
      tick(7);
      m_cnt[1] = 1;
      expect_val("t2_bounce_glitch", pk()); chk(32'(counters));

      // 2-bit wrap and saturate instances
      for (int k = 0; k < 5; k++) begin
         press2();
         if (k == 2) begin
            expect_val("t3_wrap_ovf_at_max", 32'(m_ovf_w)); chk(32'(ovf_w[0]));
            expect_val("t3_sat_ovf_at_max", 32'(m_ovf_s));  chk(32'(ovf_s[0]));
         end
      end
      expect_val("t3_wrap_count", 32'(m_w));     chk(32'(cnt_w[1:0]));
      expect_val("t3_wrap_ovf", 32'(m_ovf_w));   chk(32'(ovf_w[0]));
      expect_val("t3_sat_count", 32'(m_s));      chk(32'(cnt_s[1:0]));
      expect_val("t3_sat_ovf", 32'(m_ovf_s));    chk(32'(ovf_s[0]));
      cm2 = 3'b001;
      tick(1);
      cm2 = 3'b000;
      expect_val("t3_wrap_cleared", 0);     chk(32'(cnt_w[1:0]));
      expect_val("t3_wrap_ovf_cleared", 0); chk(32'(ovf_w[0]));
      expect_val("t3_sat_cleared", 0);      chk(32'(cnt_s[1:0]));
      expect_val("t3_sat_ovf_cleared", 0);  chk(32'(ovf_s[0]));

      // clear_all lands in the same cycle as a press event
      buttons = 3'b001;
      tick(4);
      clear_all = 1'b1;
      tick(1);
      clear_all = 1'b0;
      m_cnt = '{0, 0, 0};
      expect_val("t4_collision_cleared", pk()); chk(32'(counters));
      tick(3);
      buttons = 3'b000;
      tick(7);
      expect_val("t4_event_lost", pk()); chk(32'(counters));
      press(3'b001);
      expect_val("t4_next_press", pk()); chk(32'(counters));

      // build counts {2,5,7} then exercise the snapshot handshake
      for (int k = 0; k < 5; k++) press(3'b110);
      for (int k = 0; k < 2; k++) press(3'b100);
      press(3'b001);
      expect_val("t5_counts_257", 32'h00070502); chk(32'(counters));
      snap_req = 1'b1;
      tick(1);
      snap_req = 1'b0;
      expect_val("t5_valid_set", 1);     chk(32'(snap_valid));
      expect_val("t5_data", pk());       chk(32'(snap_data));
      buttons = 3'b001;
      tick(3);
      snap_req = 1'b1;
      tick(1);
      snap_req = 1'b0;
      tick(3);
      buttons = 3'b000;
      tick(7);
      expect_val("t5_valid_held", 1);         chk(32'(snap_valid));
      expect_val("t5_data_stable", 32'h00070502); chk(32'(snap_data));
      m_cnt[0] = 3;
      expect_val("t5_live_moved", pk());      chk(32'(counters));
      snap_ready = 1'b1;
      snap_req   = 1'b1;
      tick(1);
      snap_ready = 1'b0;
      snap_req   = 1'b0;
      expect_val("t5_valid_dropped", 0);   chk(32'(snap_valid));
      tick(2);
      expect_val("t5_req_on_done_ignored", 0); chk(32'(snap_valid));
      snap_ready = 1'b1;
      tick(2);
      snap_ready = 1'b0;
      snap_req = 1'b1;
      tick(1);
      snap_req = 1'b0;
      expect_val("t5_resnap_valid", 1);  chk(32'(snap_valid));
      expect_val("t5_resnap_data", pk()); chk(32'(snap_data));

      // reset in the middle of a debounce and while a snapshot is held
      buttons = 3'b100;
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      m_cnt = '{0, 0, 0};
      expect_val("t6_counters", 0);   chk(32'(counters));
      expect_val("t6_overflow", 0);   chk(32'(overflow));
      expect_val("t6_snap_valid", 0); chk(32'(snap_valid));
      expect_val("t6_snap_data", 0);  chk(32'(snap_data));
      tick(1);
      buttons = 3'b000;
      tick(8);
      expect_val("t6_pending_dropped", pk()); chk(32'(counters));

      $display("Result: errors=%0d of %0d checks", errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mouse_button_counter_array.md
Name: mouse_button_counter_array

Overview:
- Parametrised successor to the fixed three-button press counter.
- Counts debounced press events (rising edges) on NUM_BUTTONS button lines from the PS/2 packet decoder, with configurable counter width and a wrap or saturate mode.
- Adds per-channel clear, sticky overflow flags and an atomic snapshot readout with a valid/ready handshake.
- Sits between the PS/2 packet decoder and the host register interface.

Parameters:
- NUM_BUTTONS, 3: number of button channels (1..8).
- CNT_WIDTH, 8: counter width per channel (2..16).
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a level change (1..255); a value of 1 means no filtering.
- SATURATE, 0: 0 = wrap at 2^CNT_WIDTH; 1 = hold at max.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- buttons, input, NUM_BUTTONS: raw button levels, clk-synchronous, bit i = channel i.
- clear_mask, input, NUM_BUTTONS: single-cycle per-channel clear of counter and overflow flag.
- clear_all, input, 1: single-cycle clear of all channels.
- snap_req, input, 1: single-cycle request to capture all counters.
- snap_valid, output, 1: snapshot holds valid data.
- snap_ready, input, 1: consumer accepts the snapshot.
- snap_data, output, NUM_BUTTONS*CNT_WIDTH: captured counters, channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].
- counters, output, NUM_BUTTONS*CNT_WIDTH: live counters, same packing.
- overflow, output, NUM_BUTTONS: sticky per-channel overflow flags.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All counters, overflow, snap_valid and snap_data go to 0.
  - Debounce filter state goes to 0 (released) and stability counters go to 0.
  - Reset mid-debounce or mid-handshake discards all state; nothing is held over.
- Debounce, per channel:
  - Filtered level changes only after the raw level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle where raw equals filtered restarts the stability count at 0.
- Press event: a filtered 0->1 transition produces a one-cycle event.
  - The counter updates on the edge after the filtered level changes.
  - Total latency from the first stable raw-high cycle to the counter update is DEBOUNCE_CYCLES+1 cycles.
  - Releases are never counted.
- Increment:
  - Wrap mode (SATURATE=0): max -> 0, and the overflow flag is set in the same cycle.
  - Saturate mode (SATURATE=1): at max the counter holds; the overflow flag is set on the first press that is dropped.
  - Overflow stays set until that channel is cleared or rst is asserted.
- Clear priority:
  - clear_all or clear_mask[i] takes precedence over a same-cycle event: the counter and flag go to 0 and the event is lost.
  - Clear does not affect the debounce state or the snapshot.
- Snapshot handshake:
  - snap_req while snap_valid=0: snap_data captures the pre-update counter values of that cycle (a same-cycle increment or clear is not included), and snap_valid=1 on the next cycle.
  - snap_data is stable while snap_valid=1.
  - Transfer completes when snap_valid and snap_ready are both 1; snap_valid deasserts on the next cycle.
  - snap_req while snap_valid=1 is ignored, including in the cycle the transfer completes; the requester retries later.
  - snap_ready while snap_valid=0 has no effect.
- Outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Package mouse_counter_pkg:
  - localparam max-count helper.
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - Packing macro/function for channel slice indices.
- Sub-module button_debounce_counter, one instance per channel via generate:
  - Contains the debounce filter, edge detector, counter and overflow flag.
  - Parameters: CNT_WIDTH, DEBOUNCE_CYCLES, SATURATE.
  - Ports: clk, rst, btn, clear, count, ovf.
- The top level holds the clear fan-out, the snapshot register and the handshake FSM.
  - FSM states: IDLE (snap_valid=0) and HOLD (snap_valid=1).

Test Plan:
1. Reset then single press, defaults: buttons=3'b001 held 10 cycles -> counters[7:0]=1 exactly 5 cycles after the first high sample; other channels 0; overflow=0.
2. Bounce rejection: buttons[1] toggles 1,0,1,1,0 then held high 4 cycles -> exactly one increment; counters[15:8]=1; a glitch of 3 cycles never counts.
3. Wrap vs saturate, CNT_WIDTH=2:
   - SATURATE=0, 5 presses -> count 1, overflow[0]=1.
   - SATURATE=1, 5 presses -> count 3, overflow[0]=1.
   - clear_mask=3'b001 -> count 0, flag 0.
4. Clear/press collision: press event in the same cycle as clear_all -> all counters 0 next cycle; the next press gives count 1.
5. Snapshot:
   - With counts {2,5,7}, pulse snap_req with snap_ready=0 for 6 cycles while channel 0 gets more presses -> snap_valid=1, snap_data stays {2,5,7}.
   - A second snap_req is ignored.
   - snap_ready=1 -> snap_valid=0 next cycle.
6. Reset mid-operation: rst=1 during debounce of channel 2 and while snap_valid=1 -> all outputs 0 next cycle; the pending press is not counted after rst drops.
